// File: rtl/spi_a2d_if.sv
// ----------------------------------------------------------------------------
// spi_a2d_if
//   Transaction handshake between the A2D command sequencer and the SPI master.
//
//   spi_wrt      1   one-cycle transaction request (sequencer -> SPI master)
//   spi_cmd     16   command word, held stable between requests
//   spi_done     1   transaction complete (SPI master -> sequencer)
//   spi_rd_data 16   word shifted in by the SPI master, valid with spi_done
//
//   Modports: master = sequencer side, slave = SPI master side.
// ----------------------------------------------------------------------------
interface spi_a2d_if;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_done;
  logic [15:0] spi_rd_data;

  modport master (
    output spi_wrt,
    output spi_cmd,
    input  spi_done,
    input  spi_rd_data
  );

  modport slave (
    input  spi_wrt,
    input  spi_cmd,
    output spi_done,
    output spi_rd_data
  );
endinterface

// File: rtl/spi_a2d_sequencer.sv
// ----------------------------------------------------------------------------
// spi_a2d_sequencer
//   Round-robin conversion sequencer for an 8-channel SPI A2D. Each round
//   issues NUM_CH+1 transactions; transaction k sends the command for channel
//   k and returns the result of channel k-1 (the A2D is pipelined by one
//   conversion), so the final transaction is a dummy on channel 0 that only
//   collects the last result. Rounds start on strt, or periodically every
//   PERIOD cycles while en is high. A missing spi_done aborts the round.
//
//   Ports
//     clk          system clock, rising edge
//     rst          synchronous active-high reset
//     en           continuous sampling enable
//     strt         single-round start pulse (ignored while busy)
//     spi          spi_a2d_if.master: spi_wrt / spi_cmd / spi_done / spi_rd_data
//     res_vld      one-cycle result valid
//     res_ch       channel of res_data
//     res_data     12-bit conversion result
//     rnd_done     one-cycle pulse, full round complete
//     busy         round in progress
//     err          one-cycle pulse on spi_done timeout
//
//   Parameters
//     NUM_CH   channels per round, 1..8
//     GAP_CYC  idle cycles between spi_done and the next spi_wrt
//     TIMEOUT  cycles after spi_wrt at which err pulses if no spi_done (>= 2)
//     PERIOD   cycles between round starts in continuous mode (>= 1)
// ----------------------------------------------------------------------------
module spi_a2d_sequencer #(
  parameter int NUM_CH  = 8,
  parameter int GAP_CYC = 4,
  parameter int TIMEOUT = 4096,
  parameter int PERIOD  = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        strt,
  spi_a2d_if.master   spi,
  output logic        res_vld,
  output logic [2:0]  res_ch,
  output logic [11:0] res_data,
  output logic        rnd_done,
  output logic        busy,
  output logic        err
);

  localparam int KW = $clog2(NUM_CH + 2);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int PW = $clog2(PERIOD + 1);

  localparam logic [KW-1:0] K_LAST   = KW'(NUM_CH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [PW-1:0] PER_LOAD = PW'(PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    GAP
  } state_t;

  state_t        state, state_nxt;
  logic [KW-1:0] k, k_nxt;
  logic [TW-1:0] tmo_cnt;
  logic [GW-1:0] gap_cnt;
  logic [PW-1:0] per_cnt;
  logic [2:0]    ch_nxt;
  logic          rnd_start;
  logic          done_acc;
  logic          tmo_hit;

  // Only the low 12 bits of the returned word carry the conversion.
  logic unused_rd_hi;
  assign unused_rd_hi = ^spi.spi_rd_data[15:12];

  // The dummy transaction that closes a round addresses channel 0.
  assign ch_nxt = (k_nxt < K_LAST) ? 3'(k_nxt) : 3'd0;

  // ---- next-state / control decode ----
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    rnd_start = 1'b0;
    done_acc  = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (strt || (en && (per_cnt == '0))) begin
          state_nxt = ISSUE;
          k_nxt     = '0;
          rnd_start = 1'b1;
        end
      end
      ISSUE: begin
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A done arriving on the terminal-count cycle is still accepted.
        if (spi.spi_done) begin
          done_acc = 1'b1;
          if (k == K_LAST) begin
            state_nxt = IDLE;
            k_nxt     = '0;
          end else begin
            k_nxt     = k + KW'(1);
            state_nxt = (GAP_CYC == 0) ? ISSUE : GAP;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
          k_nxt     = '0;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = ISSUE;
        end
      end
      default: begin
        state_nxt = IDLE;
        k_nxt     = '0;
      end
    endcase
  end

  // ---- registered state, counters and outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      k               <= '0;
      tmo_cnt         <= '0;
      gap_cnt         <= '0;
      per_cnt         <= '0;
      spi.spi_wrt     <= 1'b0;
      spi.spi_cmd     <= 16'h0000;
      res_vld         <= 1'b0;
      res_ch          <= 3'd0;
      res_data        <= 12'h000;
      rnd_done        <= 1'b0;
      busy            <= 1'b0;
      err             <= 1'b0;
    end else begin
      state       <= state_nxt;
      k           <= k_nxt;
      spi.spi_wrt <= (state_nxt == ISSUE);
      busy        <= (state_nxt != IDLE);
      res_vld     <= done_acc && (k != '0);
      rnd_done    <= done_acc && (k == K_LAST);
      err         <= tmo_hit;

      if (state_nxt == ISSUE) begin
        spi.spi_cmd <= {2'b00, ch_nxt, 11'h000};
      end

      // Result of transaction k belongs to channel k-1; k=0 returns stale data.
      if (done_acc && (k != '0)) begin
        res_ch   <= 3'(k - KW'(1));
        res_data <= spi.spi_rd_data[11:0];
      end

      // tmo_cnt equals cycles elapsed since spi_wrt while in WAIT_DONE,
      // so err lands exactly TIMEOUT cycles after the request.
      if (state == ISSUE) begin
        tmo_cnt <= TW'(1);
      end else if (state == WAIT_DONE) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end

      if (state == GAP) begin
        gap_cnt <= gap_cnt + GW'(1);
      end else begin
        gap_cnt <= '0;
      end

      // Reaching zero mid-round holds, giving a back-to-back restart.
      if (rnd_start) begin
        per_cnt <= PER_LOAD;
      end else if (en && (per_cnt != '0)) begin
        per_cnt <= per_cnt - PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_spi_a2d_sequencer.sv
`timescale 1ns/1ps
module tb_spi_a2d_sequencer;

  localparam int GAP_C = 4;
  localparam int TMO_C = 100;

  logic clk = 1'b0;
  logic rst, en, strt, en_b, strt_b;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_a2d_if ifa ();
  spi_a2d_if ifb ();

  logic        res_vld, rnd_done, busy, err;
  logic [2:0]  res_ch;
  logic [11:0] res_data;
  logic        b_res_vld, b_rnd_done, b_busy, b_err;
  logic [2:0]  b_res_ch;
  logic [11:0] b_res_data;

  spi_a2d_sequencer #(.NUM_CH(8), .GAP_CYC(GAP_C), .TIMEOUT(TMO_C), .PERIOD(1000)) dut_a (
    .clk(clk), .rst(rst), .en(en), .strt(strt), .spi(ifa),
    .res_vld(res_vld), .res_ch(res_ch), .res_data(res_data),
    .rnd_done(rnd_done), .busy(busy), .err(err)
  );

  spi_a2d_sequencer #(.NUM_CH(8), .GAP_CYC(GAP_C), .TIMEOUT(TMO_C), .PERIOD(100)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .strt(strt_b), .spi(ifb),
    .res_vld(b_res_vld), .res_ch(b_res_ch), .res_data(b_res_data),
    .rnd_done(b_rnd_done), .busy(b_busy), .err(b_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---- SPI slave model A: done 40 cycles after wrt, data = A00 + previous cmd channel
  int          a_dly  = 40;
  bit          a_drop = 1'b0;
  int          a_cnt  = 0;
  logic [2:0]  a_ch   = 3'd0;
  logic [2:0]  a_last = 3'd0;
  logic [11:0] a_dat  = 12'h000;
  int          done_cyc[$];

  always @(negedge clk) begin
    ifa.spi_done = 1'b0;
    if (a_cnt > 0) begin
      a_cnt--;
      if (a_cnt == 0 && !(a_drop && a_ch == 3'd3)) begin
        ifa.spi_done    = 1'b1;
        ifa.spi_rd_data = {4'h0, a_dat};
        done_cyc.push_back(cyc);
      end
    end
    if (ifa.spi_wrt) begin
      a_cnt  = a_dly;
      a_ch   = ifa.spi_cmd[13:11];
      a_dat  = 12'hA00 + 12'(a_last);
      a_last = a_ch;
    end
  end

  // ---- SPI slave model B
  int          b_cnt  = 0;
  logic [2:0]  b_last = 3'd0;
  logic [11:0] b_dat  = 12'h000;

  always @(negedge clk) begin
    ifb.spi_done = 1'b0;
    if (b_cnt > 0) begin
      b_cnt--;
      if (b_cnt == 0) begin
        ifb.spi_done    = 1'b1;
        ifb.spi_rd_data = {4'h0, b_dat};
      end
    end
    if (ifb.spi_wrt) begin
      b_cnt  = 40;
      b_dat  = 12'hA00 + 12'(b_last);
      b_last = ifb.spi_cmd[13:11];
    end
  end

  // ---- event logs
  int          wrt_cyc[$];
  logic [15:0] wrt_cmd[$];
  int          res_cyc[$];
  logic [2:0]  res_ch_q[$];
  logic [11:0] res_dat_q[$];
  int          rnd_cyc[$];
  int          err_cyc[$];
  int          busy_fall[$];
  bit          busy_prev = 1'b0;

  always @(negedge clk) begin
    if (ifa.spi_wrt === 1'b1) begin
      wrt_cyc.push_back(cyc);
      wrt_cmd.push_back(ifa.spi_cmd);
    end
    if (res_vld === 1'b1) begin
      res_cyc.push_back(cyc);
      res_ch_q.push_back(res_ch);
      res_dat_q.push_back(res_data);
    end
    if (rnd_done === 1'b1) rnd_cyc.push_back(cyc);
    if (err === 1'b1) err_cyc.push_back(cyc);
    if (busy_prev && busy === 1'b0) busy_fall.push_back(cyc);
    busy_prev = (busy === 1'b1);
  end

  int          b_wrt_cyc[$];
  logic [15:0] b_wrt_cmd[$];
  int          b_rnd_cyc[$];
  int          b_res_n = 0;
  int          b_err_n = 0;
  logic [2:0]  b_last_ch = 3'd0;
  logic [11:0] b_last_dat = 12'h000;

  always @(negedge clk) begin
    if (ifb.spi_wrt === 1'b1) begin
      b_wrt_cyc.push_back(cyc);
      b_wrt_cmd.push_back(ifb.spi_cmd);
    end
    if (b_res_vld === 1'b1) b_res_n++;
    if (b_err === 1'b1) b_err_n++;
    if (b_rnd_done === 1'b1) begin
      b_rnd_cyc.push_back(cyc);
      b_last_ch  = b_res_ch;
      b_last_dat = b_res_data;
    end
  end

  task automatic clear_logs();
    wrt_cyc.delete(); wrt_cmd.delete(); res_cyc.delete(); res_ch_q.delete();
    res_dat_q.delete(); rnd_cyc.delete(); err_cyc.delete(); busy_fall.delete();
    done_cyc.delete();
  endtask

  task automatic pulse_strt();
    strt = 1'b1;
    @(negedge clk);
    strt = 1'b0;
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_wrt"},      32'(ifa.spi_wrt), 0);
    chk({pfx, "_cmd"},      32'(ifa.spi_cmd), 0);
    chk({pfx, "_res_vld"},  32'(res_vld), 0);
    chk({pfx, "_res_ch"},   32'(res_ch), 0);
    chk({pfx, "_res_data"}, 32'(res_data), 0);
    chk({pfx, "_rnd_done"}, 32'(rnd_done), 0);
    chk({pfx, "_busy"},     32'(busy), 0);
    chk({pfx, "_err"},      32'(err), 0);
  endtask

  initial begin
    int s;
    rst = 1'b1; en = 1'b0; strt = 1'b0; en_b = 1'b0; strt_b = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic round with gap timing
    clear_logs();
    s = cyc;
    pulse_strt();
    for (int i = 0; i < 2000 && rnd_cyc.size() == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("basic_rnd_cnt", rnd_cyc.size(), 1);
    chk("basic_wrt_cnt", wrt_cyc.size(), 9);
    chk("basic_res_cnt", res_cyc.size(), 8);
    chk("basic_err_cnt", err_cyc.size(), 0);
    if (wrt_cyc.size() > 0) chk("first_wrt_latency", wrt_cyc[0], s + 1);
    for (int j = 0; j < 9 && j < wrt_cyc.size(); j++)
      chk($sformatf("basic_cmd%0d", j), 32'(wrt_cmd[j]), (j < 8) ? (j << 11) : 0);
    for (int j = 0; j < 8 && j < res_cyc.size(); j++) begin
      chk($sformatf("basic_res_ch%0d", j), 32'(res_ch_q[j]), j);
      chk($sformatf("basic_res_dat%0d", j), 32'(res_dat_q[j]), 32'h0A00 + j);
    end
    for (int j = 0; j < 8 && j + 1 < wrt_cyc.size() && j < done_cyc.size(); j++)
      chk($sformatf("gap_done_to_wrt%0d", j), wrt_cyc[j + 1] - done_cyc[j], GAP_C + 1);
    if (rnd_cyc.size() > 0 && res_cyc.size() == 8)
      chk("rnd_with_last_res", rnd_cyc[0], res_cyc[7]);
    chk("basic_busy_falls", busy_fall.size(), 1);
    if (busy_fall.size() > 0 && rnd_cyc.size() > 0)
      chk("busy_fall_at_rnd_done", busy_fall[0], rnd_cyc[0]);
    chk("basic_busy_after", 32'(busy), 0);

    // Timeout on the 4th transaction
    clear_logs();
    a_drop = 1'b1;
    pulse_strt();
    for (int i = 0; i < 2000 && err_cyc.size() == 0 && rnd_cyc.size() == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("tmo_err_cnt", err_cyc.size(), 1);
    chk("tmo_wrt_cnt", wrt_cyc.size(), 4);
    chk("tmo_res_cnt", res_cyc.size(), 2);
    chk("tmo_rnd_cnt", rnd_cyc.size(), 0);
    if (err_cyc.size() > 0 && wrt_cyc.size() >= 4)
      chk("tmo_err_latency", err_cyc[0] - wrt_cyc[3], TMO_C);
    if (res_cyc.size() == 2) begin
      chk("tmo_res0", {res_ch_q[0], res_dat_q[0]}, {3'd0, 12'hA00});
      chk("tmo_res1", {res_ch_q[1], res_dat_q[1]}, {3'd1, 12'hA01});
    end
    chk("tmo_busy_after", 32'(busy), 0);
    a_drop = 1'b0;

    // Restart after timeout, with a strt pulse while busy
    clear_logs();
    pulse_strt();
    repeat (100) @(negedge clk);
    pulse_strt();
    for (int i = 0; i < 2000 && rnd_cyc.size() == 0; i++) @(negedge clk);
    repeat (150) @(negedge clk);
    chk("restart_wrt_cnt", wrt_cyc.size(), 9);
    if (wrt_cyc.size() > 0) chk("restart_cmd0", 32'(wrt_cmd[0]), 0);
    chk("restart_res_cnt", res_cyc.size(), 8);
    chk("restart_rnd_cnt", rnd_cyc.size(), 1);

    // Done on the terminal-count cycle wins over timeout
    clear_logs();
    a_dly = TMO_C - 1;
    pulse_strt();
    for (int i = 0; i < 3000 && rnd_cyc.size() == 0 && err_cyc.size() == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("tc_err_cnt", err_cyc.size(), 0);
    chk("tc_res_cnt", res_cyc.size(), 8);
    chk("tc_rnd_cnt", rnd_cyc.size(), 1);
    if (res_cyc.size() > 0 && wrt_cyc.size() > 1)
      chk("tc_res_latency", res_cyc[0] - wrt_cyc[1], TMO_C);
    a_dly = 40;

    // Reset mid-round during the 5th transaction
    clear_logs();
    pulse_strt();
    for (int i = 0; i < 1000 && wrt_cyc.size() < 5; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs("midrst");
    rst = 1'b0;
    clear_logs();
    repeat (100) @(negedge clk);
    chk("stray_done_sent", done_cyc.size(), 1);
    chk("stray_res_cnt", res_cyc.size(), 0);
    chk("stray_wrt_cnt", wrt_cyc.size(), 0);
    chk("stray_busy", 32'(busy), 0);

    // Continuous mode, PERIOD=1000; en dropped during the third round
    clear_logs();
    en = 1'b1;
    for (int i = 0; i < 3000 && wrt_cyc.size() < 19; i++) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 1000 && rnd_cyc.size() < 3; i++) @(negedge clk);
    repeat (1100) @(negedge clk);
    if (wrt_cyc.size() >= 19) begin
      chk("period_1_2", wrt_cyc[9] - wrt_cyc[0], 1000);
      chk("period_2_3", wrt_cyc[18] - wrt_cyc[9], 1000);
    end
    chk("cont_wrt_cnt", wrt_cyc.size(), 27);
    chk("cont_rnd_cnt", rnd_cyc.size(), 3);
    chk("cont_busy_after", 32'(busy), 0);

    // Continuous mode, PERIOD=100 shorter than a round: back-to-back
    en_b = 1'b1;
    for (int i = 0; i < 2000 && b_wrt_cyc.size() < 10; i++) @(negedge clk);
    en_b = 1'b0;
    for (int i = 0; i < 1000 && b_rnd_cyc.size() < 2; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    if (b_wrt_cyc.size() >= 10 && b_rnd_cyc.size() > 0) begin
      chk("b2b_issue_after_rnd", b_wrt_cyc[9] - b_rnd_cyc[0], 1);
      chk("b2b_cmd", 32'(b_wrt_cmd[9]), 0);
    end
    chk("b2b_rnd_cnt", b_rnd_cyc.size(), 2);
    chk("b2b_res_cnt", b_res_n, 16);
    chk("b2b_err_cnt", b_err_n, 0);
    chk("b2b_last_res", {b_last_ch, b_last_dat}, {3'd7, 12'hA07});
    chk("b2b_busy_after", 32'(b_busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
